// File: rtl/lsu_handshake.sv
// Load/store unit bridging the execute/memory stage to a variable-latency data memory.
// Optional macro LSU_PERF_EN adds saturating access / wait-cycle counters.
module lsu_handshake #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                req_load,
    input  logic                req_store,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [2:0]          req_funct3,
    output logic                stall,
    output logic [XLEN-1:0]     load_data,
    output logic                load_valid,
    output logic                fault,
    output logic [1:0]          fault_code,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_be,
    output logic                mem_rd_en,
    output logic                mem_wr_en,
    input  logic                mem_ready,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic [31:0]         perf_accesses,
    output logic [31:0]         perf_wait_cycles
);
    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_q;
    logic            dir_q;
    logic [2:0]      f3_q;
    logic [LW-1:0]   lane_q;
    logic [CW-1:0]   wait_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q, load_data_q;
    logic [NB-1:0]   mem_be_q;
    logic            rd_en_q, wr_en_q, load_valid_q, rfault_q;

    logic            req_any, illegal, misal, req_ok, req_fault, timeout_hit;
    logic [LW-1:0]   lane;
    logic [NB-1:0]   be_d;
    logic [XLEN-1:0] wdata_d, sh, ext;

    assign req_any = req_load | req_store;
    assign lane    = req_addr[LW-1:0];

    always_comb begin
        illegal = 1'b0;
        if (req_load && req_store)
            illegal = 1'b1;
        else if (req_load)
            illegal = (req_funct3 == 3'b111) ||
                      ((req_funct3 == 3'b011 || req_funct3 == 3'b110) && XLEN != 64);
        else if (req_store)
            illegal = req_funct3[2] || (req_funct3 == 3'b011 && XLEN != 64);
        case (req_funct3[1:0])
            2'b01:   misal = req_addr[0];
            2'b10:   misal = req_addr[1:0] != 2'b00;
            2'b11:   misal = req_addr[2:0] != 3'b000;
            default: misal = 1'b0;
        endcase
    end

    assign req_ok    = (state_q == IDLE) && req_any && !illegal && !misal;
    assign req_fault = !rst && (state_q == IDLE) && req_any && (illegal || misal);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_q == TO_LAST);

    // Bytes are replicated across lanes; wider sizes are shifted into their lane.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   be_d = NB'(1) << lane;
            2'b01:   be_d = NB'(2'b11) << lane;
            2'b10:   be_d = NB'(4'hF) << lane;
            default: be_d = '1;
        endcase
        wdata_d = (req_funct3[1:0] == 2'b00) ? {NB{req_wdata[7:0]}}
                                             : req_wdata << {lane, 3'b000};
    end

    always_comb begin
        sh = mem_rdata >> {lane_q, 3'b000};
        case (f3_q)
            3'b000:  ext = XLEN'($signed(sh[7:0]));
            3'b100:  ext = XLEN'(sh[7:0]);
            3'b001:  ext = XLEN'($signed(sh[15:0]));
            3'b101:  ext = XLEN'(sh[15:0]);
            3'b010:  ext = XLEN'($signed(sh[31:0]));
            3'b110:  ext = XLEN'(sh[31:0]);
            default: ext = sh;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dir_q        <= 1'b0;
            f3_q         <= '0;
            lane_q       <= '0;
            wait_q       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            rfault_q     <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            rfault_q     <= 1'b0;
            case (state_q)
                IDLE: if (req_ok) begin
                    state_q     <= BUSY;
                    dir_q       <= req_store;
                    f3_q        <= req_funct3;
                    lane_q      <= lane;
                    wait_q      <= '0;
                    mem_addr_q  <= {req_addr[ADDR_W-1:LW], LW'(0)};
                    mem_wdata_q <= wdata_d;
                    mem_be_q    <= be_d;
                    rd_en_q     <= req_load;
                    wr_en_q     <= req_store;
                end
                BUSY: if (mem_ready) begin
                    state_q <= RESP;
                    rd_en_q <= 1'b0;
                    wr_en_q <= 1'b0;
                    if (!dir_q) begin
                        load_data_q  <= ext;
                        load_valid_q <= 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_q     <= RESP;
                    rd_en_q     <= 1'b0;
                    wr_en_q     <= 1'b0;
                    load_data_q <= '0;
                    rfault_q    <= 1'b1;
                end else if (wait_q != '1) begin
                    wait_q <= wait_q + 1'b1;
                end
                // RESP never looks at the request, so a held instruction is not reissued.
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall      = !rst && (req_ok || state_q == BUSY);
    assign fault      = rfault_q || req_fault;
    assign fault_code = rfault_q ? 2'b11 : (req_fault ? (illegal ? 2'b10 : 2'b01) : 2'b00);
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign mem_rd_en  = rd_en_q;
    assign mem_wr_en  = wr_en_q;

`ifdef LSU_PERF_EN
    logic [31:0] perf_acc_q, perf_wait_q;
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            perf_acc_q  <= '0;
            perf_wait_q <= '0;
        end else if (state_q == BUSY) begin
            if (mem_ready && perf_acc_q != '1)
                perf_acc_q <= perf_acc_q + 1'b1;
            else if (!mem_ready && perf_wait_q != '1)
                perf_wait_q <= perf_wait_q + 1'b1;
        end
    end
    assign perf_accesses    = perf_acc_q;
    assign perf_wait_cycles = perf_wait_q;
`else
    assign perf_accesses    = '0;
    assign perf_wait_cycles = '0;
`endif
endmodule

// File: tb/tb_lsu_handshake.sv
// Scoreboard bench for lsu_handshake (XLEN=32, TIMEOUT_CYC=4): responses, memory
// requests and stall-run lengths are each queued at issue time and popped by monitors.
module tb_lsu_handshake;
    logic        CLK = 1'b0;
    logic        rst;
    logic        req_load, req_store;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        stall, load_valid, fault, mem_rd_en, mem_wr_en, mem_ready;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata, perf_accesses, perf_wait_cycles;
    logic [1:0]  fault_code;
    logic [3:0]  mem_be;

    lsu_handshake #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut (
        .CLK(CLK), .rst(rst), .req_load(req_load), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .fault(fault), .fault_code(fault_code), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .perf_accesses(perf_accesses), .perf_wait_cycles(perf_wait_cycles));

    always #5 CLK = ~CLK;

    typedef struct { bit is_fault; bit chk_data; logic [31:0] data; logic [1:0] code; } resp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int len; } memx_t;
    resp_t rq[$];
    memx_t mq[$];
    int    sq[$];
    int    n_chk = 0, n_fail = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_resp(bit isf, bit cd, logic [31:0] d, logic [1:0] c);
        resp_t r;
        r.is_fault = isf; r.chk_data = cd; r.data = d; r.code = c;
        rq.push_back(r);
    endtask

    task automatic exp_mem(bit wr, logic [31:0] a, logic [3:0] be, logic [31:0] wd, int len);
        memx_t m;
        m.wr = wr; m.addr = a; m.be = be; m.wdata = wd; m.len = len;
        mq.push_back(m);
    endtask

    // Memory model: asserts mem_ready after `lat` wait cycles of an access.
    int          lat = 0, bcnt = 0;
    logic [31:0] rdata_v = '0;
    always @(negedge CLK) begin
        mem_rdata = rdata_v;
        if (mem_rd_en || mem_wr_en) begin
            mem_ready = (bcnt == lat);
            bcnt++;
        end else begin
            mem_ready = 1'b0;
            bcnt = 0;
        end
    end

    always @(negedge CLK) begin
        if (!rst && (load_valid || fault)) begin
            chk("lv_fault_excl", {63'd0, load_valid && fault}, 64'd0);
            if (rq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_resp: got lv=%0b fault=%0b expected none", load_valid, fault);
            end else begin
                resp_t r;
                r = rq.pop_front();
                chk("resp_kind", {63'd0, fault}, {63'd0, r.is_fault});
                if (r.is_fault) chk("fault_code", {62'd0, fault_code}, {62'd0, r.code});
                if (r.chk_data) chk("load_data", {32'd0, load_data}, {32'd0, r.data});
            end
        end
    end

    bit    prev_en = 1'b0;
    int    mrun = 0;
    memx_t cur;
    always @(negedge CLK) begin
        if (mem_rd_en || mem_wr_en) begin
            chk("mem_dir_excl", {63'd0, mem_rd_en && mem_wr_en}, 64'd0);
            if (!prev_en) begin
                mrun = 0;
                if (mq.size() == 0) begin
                    n_chk++; n_fail++;
                    cur.len = -1;
                    $display("FAIL unexpected_access: got addr=%0h expected none", mem_addr);
                end else begin
                    cur = mq.pop_front();
                    chk("mem_wr", {63'd0, mem_wr_en}, {63'd0, cur.wr});
                    chk("mem_addr", {32'd0, mem_addr}, {32'd0, cur.addr});
                    chk("mem_be", {60'd0, mem_be}, {60'd0, cur.be});
                    if (cur.wr) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, cur.wdata});
                end
            end
            mrun++;
        end else if (prev_en && cur.len >= 0) begin
            chk("mem_len", 64'(mrun), 64'(cur.len));
        end
        prev_en = mem_rd_en || mem_wr_en;
    end

    int srun = 0;
    always @(negedge CLK) begin
        if (stall) srun++;
        else if (srun > 0) begin
            if (sq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_stall: got %0d cycles expected none", srun);
            end else chk("stall_len", 64'(srun), 64'(sq.pop_front()));
            srun = 0;
        end
    end

    // Holds the request as a frozen pipeline would, until stall is released.
    task automatic issue(bit ld, bit st, logic [31:0] a, logic [31:0] wd, logic [2:0] f3);
        int b = 0;
        req_load = ld; req_store = st; req_addr = a; req_wdata = wd; req_funct3 = f3;
        @(negedge CLK);
        while (stall && b < 100) begin
            @(negedge CLK);
            b++;
        end
        if (b >= 100) begin
            n_chk++; n_fail++;
            $display("FAIL stall_timeout: got stall stuck expected release");
        end
        @(posedge CLK); #1;
        req_load = 1'b0; req_store = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_load = 0; req_store = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
        mem_ready = 0; mem_rdata = 0;
        #1;
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
        chk("rst_wr_en", {63'd0, mem_wr_en}, 64'd0);
        chk("rst_fault", {63'd0, fault}, 64'd0);
        chk("rst_load_data", {32'd0, load_data}, 64'd0);
        chk("rst_perf", {perf_accesses, perf_wait_cycles}, 64'd0);
        @(posedge CLK); @(posedge CLK); #1;
        rst = 1'b0;

        lat = 0; rdata_v = 32'hDEADBEEF;
        exp_mem(0, 32'h100, 4'hF, 0, 1); sq.push_back(2); exp_resp(0, 1, 32'hDEADBEEF, 0);
        issue(1, 0, 32'h100, 0, 3'b010);

        rdata_v = 32'h80112233;
        exp_mem(0, 32'h100, 4'h8, 0, 1); sq.push_back(2); exp_resp(0, 1, 32'hFFFFFF80, 0);
        issue(1, 0, 32'h103, 0, 3'b000);
        exp_mem(0, 32'h100, 4'h8, 0, 1); sq.push_back(2); exp_resp(0, 1, 32'h00000080, 0);
        issue(1, 0, 32'h103, 0, 3'b100);

        lat = 3;
        exp_mem(1, 32'h100, 4'hC, 32'hABCD0000, 4); sq.push_back(5);
        issue(0, 1, 32'h102, 32'h0000ABCD, 3'b001);

        lat = 0;
        exp_mem(1, 32'h100, 4'h2, 32'h5A5A5A5A, 1); sq.push_back(2);
        issue(0, 1, 32'h101, 32'h0000005A, 3'b000);

        rdata_v = 32'h80017FFF;
        exp_mem(0, 32'h104, 4'hC, 0, 1); sq.push_back(2); exp_resp(0, 1, 32'hFFFF8001, 0);
        issue(1, 0, 32'h106, 0, 3'b001);
        exp_mem(0, 32'h104, 4'hC, 0, 1); sq.push_back(2); exp_resp(0, 1, 32'h00008001, 0);
        issue(1, 0, 32'h106, 0, 3'b101);

        lat = 1;
        exp_mem(1, 32'h10C, 4'hF, 32'h12345678, 2); sq.push_back(3);
        issue(0, 1, 32'h10C, 32'h12345678, 3'b010);

        exp_resp(1, 0, 0, 2'b01); issue(1, 0, 32'h101, 0, 3'b010);
        exp_resp(1, 0, 0, 2'b01); issue(0, 1, 32'h103, 32'h1, 3'b001);
        exp_resp(1, 0, 0, 2'b10); issue(1, 1, 32'h100, 0, 3'b010);
        exp_resp(1, 0, 0, 2'b10); issue(1, 0, 32'h100, 0, 3'b111);
        exp_resp(1, 0, 0, 2'b10); issue(0, 1, 32'h100, 0, 3'b100);

        lat = 1000;
        exp_mem(0, 32'h104, 4'hF, 0, 4); sq.push_back(5); exp_resp(1, 1, 32'h0, 2'b11);
        issue(1, 0, 32'h104, 0, 3'b010);

        exp_mem(0, 32'h200, 4'hF, 0, 1); sq.push_back(2);
        req_load = 1; req_addr = 32'h200; req_funct3 = 3'b010;
        @(posedge CLK); @(posedge CLK); #2;
        rst = 1'b1; #1;
        chk("midrst_rd_en", {63'd0, mem_rd_en}, 64'd0);
        chk("midrst_stall", {63'd0, stall}, 64'd0);
        chk("midrst_be", {60'd0, mem_be}, 64'd0);
        req_load = 0;
        @(posedge CLK); @(posedge CLK); #1;
        rst = 1'b0; lat = 0;

        exp_resp(1, 0, 0, 2'b10); issue(1, 0, 32'h208, 0, 3'b011);

        repeat (6) @(posedge CLK);
        #1;
        chk("resp_q_empty", 64'(rq.size()), 64'd0);
        chk("mem_q_empty", 64'(mq.size()), 64'd0);
        chk("stall_q_empty", 64'(sq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
